dbus_lsu_initiator: RTL
=======================

# dbus_lsu_initiator

Load/store initiator sitting between the execute stage and the data bus. It accepts one load or store at a time from the pipeline, checks alignment, forms byte selects and lane-replicated write data, drives a request on the data bus, and waits for the memory/peripheral responder's acknowledge. Load data is extracted and sign/zero-extended, then the result or an error is returned to the pipeline as a one-cycle completion pulse.

## Interface
- `TIMEOUT_CYCLES`, default 255: WAIT cycles without `dbus_ack` before a timeout error (only with `LSU_TIMEOUT_EN`); legal range 1..65535.
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `lsu_req`  in  1  pipeline request; held with its operands until `lsu_done`
- `lsu_we`  in  1  1 = store, 0 = load
- `lsu_size`  in  2  00 byte, 01 half, 10 word, 11 treated as word
- `lsu_unsigned`  in  1  zero-extend load result (else sign-extend)
- `lsu_addr`  in  32  byte address
- `lsu_wdata`  in  32  store data, right-aligned
- `lsu_done`  out  1  one-cycle completion pulse
- `lsu_rdata`  out  32  extended load data, valid with `lsu_done` on loads; 0 otherwise
- `lsu_err`  out  1  completion carries an error, valid with `lsu_done`
- `lsu_err_code`  out  2  00 none, 01 misaligned, 10 bus timeout
- `lsu_busy`  out  1  state != IDLE
- `dbus_req`  out  1  bus request
- `dbus_w_en`  out  1  write enable
- `dbus_addr`  out  32  word-aligned address (`lsu_addr[31:2]`, 2'b00)
- `dbus_sel`  out  4  byte-lane selects
- `dbus_wdata`  out  32  lane-replicated store data
- `dbus_rdata`  in  32  read data, valid with `dbus_ack`
- `dbus_ack`  in  1  responder acknowledge, one cycle

## Operation
- States: IDLE, WAIT, RESP.
- IDLE + `lsu_req`: latch operands. Aligned -> WAIT. Misaligned (half with addr[0]=1; word/11 with addr[1:0]!=0) -> RESP, err_code 01, no bus activity.
- WAIT: `dbus_req`=1; `dbus_addr`/`dbus_sel`/`dbus_wdata`/`dbus_w_en` stable. `dbus_ack` -> capture `dbus_rdata`, RESP.
- RESP: `lsu_done`=1 for exactly one cycle, then IDLE. `lsu_req` ignored in RESP.
- Byte selects: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
- Store data: byte replicated into all 4 lanes; half replicated into both halves; word as is.
- Load extract: byte = `rdata[8*addr[1:0]+:8]`, half = `rdata[16*addr[1]+:16]`; extend to 32 per `lsu_unsigned`; size 10/11 returns full word.
- All outputs registered. Reset values: state IDLE; `lsu_done`, `lsu_err`, `lsu_busy`, `dbus_req`, `dbus_w_en` = 0; `lsu_err_code`=00; `lsu_rdata`, `dbus_addr`, `dbus_wdata`=0; `dbus_sel`=0000.
- Reset mid-transaction: `dbus_req` drops immediately (async); no `lsu_done`; a late `dbus_ack` after reset is ignored in IDLE.
- `dbus_ack` outside WAIT is ignored.

## Timing
- Cycle 0: `lsu_req` sampled in IDLE. Cycle 1: `dbus_req`=1. Ack in cycle k>=1 -> `lsu_done` in cycle k+1, `dbus_req`=0 in cycle k+1. Next request accepted in cycle k+2.
- Minimum load/store latency: 2 cycles request-to-done; throughput one access per 3 cycles.
- Misaligned: `lsu_done` with `lsu_err` in cycle 1; `dbus_req` never asserted.
- Store `lsu_rdata` is 0.

## Configuration
- `LSU_TIMEOUT_EN` defined: 16-bit counter clears on entering WAIT, increments each WAIT cycle without ack; on reaching `TIMEOUT_CYCLES`, `dbus_req` drops, RESP with err_code 10. Ack in the same cycle as expiry wins (normal completion).
- Undefined: no counter; WAIT waits indefinitely; err_code 10 never produced.

## Test plan
- Word load addr 0x28, ack in cycle 1 with rdata 0xDEADBEEF -> `dbus_addr`=0x28, sel 1111, `lsu_done` cycle 2, `lsu_rdata`=0xDEADBEEF, err 0.
- Byte store addr 0x0B, wdata 0x000000AA -> sel 1000, `dbus_wdata`=0xAAAAAAAA, `dbus_w_en`=1, done with err 0.
- Signed half load addr 0x1A, rdata 0x8001_1234 -> sel 1100, `lsu_rdata`=0xFFFF8001; same with `lsu_unsigned`=1 -> 0x00008001.
- Misaligned word load addr 0x06 -> `dbus_req` stays 0, `lsu_done` cycle 1, err 1, code 01.
- With `LSU_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, no ack -> `dbus_req` high 4 cycles, then done, err code 10; repeat with ack on 4th cycle -> normal completion.
- Assert `rst` while in WAIT with ack delayed -> `dbus_req` 0 immediately, no `lsu_done`, later ack ignored, next request completes normally.

Source files
------------

// File: rtl/dbus_lsu_initiator_if.sv
// Pipeline-side and data-bus-side signals of the load/store initiator.
// The master modport is the initiator's view; slave is the pipeline/responder view.
interface dbus_lsu_initiator_if;
   logic        lsu_req;
   logic        lsu_we;
   logic [1:0]  lsu_size;
   logic        lsu_unsigned;
   logic [31:0] lsu_addr;
   logic [31:0] lsu_wdata;
   logic        lsu_done;
   logic [31:0] lsu_rdata;
   logic        lsu_err;
   logic [1:0]  lsu_err_code;
   logic        lsu_busy;
   logic        dbus_req;
   logic        dbus_w_en;
   logic [31:0] dbus_addr;
   logic [3:0]  dbus_sel;
   logic [31:0] dbus_wdata;
   logic [31:0] dbus_rdata;
   logic        dbus_ack;

   modport master (
      input  lsu_req, lsu_we, lsu_size, lsu_unsigned, lsu_addr, lsu_wdata,
      input  dbus_rdata, dbus_ack,
      output lsu_done, lsu_rdata, lsu_err, lsu_err_code, lsu_busy,
      output dbus_req, dbus_w_en, dbus_addr, dbus_sel, dbus_wdata
   );

   modport slave (
      output lsu_req, lsu_we, lsu_size, lsu_unsigned, lsu_addr, lsu_wdata,
      output dbus_rdata, dbus_ack,
      input  lsu_done, lsu_rdata, lsu_err, lsu_err_code, lsu_busy,
      input  dbus_req, dbus_w_en, dbus_addr, dbus_sel, dbus_wdata
   );
endinterface

// File: rtl/dbus_lsu_initiator.sv
// Single-outstanding load/store initiator: alignment check, lane steering, bus wait, load extension.
// Define LSU_TIMEOUT_EN to add a WAIT-state watchdog that ends the access with err_code 10.
module dbus_lsu_initiator #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input logic                   clk,
   input logic                   rst,
   dbus_lsu_initiator_if.master  io_bus
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_badTimeout
      $error("TIMEOUT_CYCLES must be in 1..65535");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t      r_state;
   logic        r_we;
   logic        r_unsigned;
   logic [1:0]  r_size;
   logic [1:0]  r_addrLo;
   logic        r_done;
   logic        r_err;
   logic [1:0]  r_errCode;
   logic        r_busy;
   logic [31:0] r_rdata;
   logic        r_dbusReq;
   logic        r_dbusWen;
   logic [31:0] r_dbusAddr;
   logic [3:0]  r_dbusSel;
   logic [31:0] r_dbusWdata;

`ifdef LSU_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] r_tmoCnt;
`endif

   logic        w_misaligned;
   logic [3:0]  w_sel;
   logic [31:0] w_wdata;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_loadExt;

   // Request-side decode works on the live pipeline operands in IDLE.
   always_comb begin
      w_misaligned = 1'b0;
      w_sel        = 4'b1111;
      w_wdata      = io_bus.lsu_wdata;
      case (io_bus.lsu_size)
         2'b00: begin
            w_sel   = 4'b0001 << io_bus.lsu_addr[1:0];
            w_wdata = {4{io_bus.lsu_wdata[7:0]}};
         end
         2'b01: begin
            w_misaligned = io_bus.lsu_addr[0];
            w_sel        = 4'b0011 << io_bus.lsu_addr[1:0];
            w_wdata      = {2{io_bus.lsu_wdata[15:0]}};
         end
         default: begin
            w_misaligned = (io_bus.lsu_addr[1:0] != 2'b00);
         end
      endcase
   end

   // Response-side extraction uses the operands latched at acceptance.
   always_comb begin
      w_byte = io_bus.dbus_rdata[{r_addrLo, 3'b000} +: 8];
      w_half = io_bus.dbus_rdata[{r_addrLo[1], 4'b0000} +: 16];
      case (r_size)
         2'b00:   w_loadExt = {{24{w_byte[7] & ~r_unsigned}}, w_byte};
         2'b01:   w_loadExt = {{16{w_half[15] & ~r_unsigned}}, w_half};
         default: w_loadExt = io_bus.dbus_rdata;
      endcase
      if (r_we) begin
         w_loadExt = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_we        <= 1'b0;
         r_unsigned  <= 1'b0;
         r_size      <= 2'b00;
         r_addrLo    <= 2'b00;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_errCode   <= 2'b00;
         r_busy      <= 1'b0;
         r_rdata     <= '0;
         r_dbusReq   <= 1'b0;
         r_dbusWen   <= 1'b0;
         r_dbusAddr  <= '0;
         r_dbusSel   <= 4'b0000;
         r_dbusWdata <= '0;
`ifdef LSU_TIMEOUT_EN
         r_tmoCnt    <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (io_bus.lsu_req) begin
                  r_we       <= io_bus.lsu_we;
                  r_unsigned <= io_bus.lsu_unsigned;
                  r_size     <= io_bus.lsu_size;
                  r_addrLo   <= io_bus.lsu_addr[1:0];
                  r_busy     <= 1'b1;
                  if (w_misaligned) begin
                     r_state   <= S_RESP;
                     r_done    <= 1'b1;
                     r_err     <= 1'b1;
                     r_errCode <= 2'b01;
                     r_rdata   <= '0;
                  end else begin
                     r_state     <= S_WAIT;
                     r_dbusReq   <= 1'b1;
                     r_dbusWen   <= io_bus.lsu_we;
                     r_dbusAddr  <= {io_bus.lsu_addr[31:2], 2'b00};
                     r_dbusSel   <= w_sel;
                     r_dbusWdata <= w_wdata;
`ifdef LSU_TIMEOUT_EN
                     r_tmoCnt    <= '0;
`endif
                  end
               end
            end

            // An ack in the expiry cycle takes priority over the timeout.
            S_WAIT: begin
               if (io_bus.dbus_ack) begin
                  r_state   <= S_RESP;
                  r_done    <= 1'b1;
                  r_err     <= 1'b0;
                  r_errCode <= 2'b00;
                  r_rdata   <= w_loadExt;
                  r_dbusReq <= 1'b0;
                  r_dbusWen <= 1'b0;
               end
`ifdef LSU_TIMEOUT_EN
               else if (r_tmoCnt == TMO_LAST) begin
                  r_state   <= S_RESP;
                  r_done    <= 1'b1;
                  r_err     <= 1'b1;
                  r_errCode <= 2'b10;
                  r_rdata   <= '0;
                  r_dbusReq <= 1'b0;
                  r_dbusWen <= 1'b0;
               end else begin
                  r_tmoCnt <= r_tmoCnt + 16'd1;
               end
`endif
            end

            S_RESP: begin
               r_state   <= S_IDLE;
               r_done    <= 1'b0;
               r_err     <= 1'b0;
               r_errCode <= 2'b00;
               r_rdata   <= '0;
               r_busy    <= 1'b0;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign io_bus.lsu_done     = r_done;
   assign io_bus.lsu_rdata    = r_rdata;
   assign io_bus.lsu_err      = r_err;
   assign io_bus.lsu_err_code = r_errCode;
   assign io_bus.lsu_busy     = r_busy;
   assign io_bus.dbus_req     = r_dbusReq;
   assign io_bus.dbus_w_en    = r_dbusWen;
   assign io_bus.dbus_addr    = r_dbusAddr;
   assign io_bus.dbus_sel     = r_dbusSel;
   assign io_bus.dbus_wdata   = r_dbusWdata;

endmodule
